// File: rtl/ula_seq.sv
// Byte-serial ALU sequencer: walks up to four operand bytes through an external
// 8-bit ALU, one byte per cycle, and returns the assembled 32-bit result.
module ula_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_cin,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_s,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_cout,
  output logic        busy
);

  if (NBYTES != 4) begin : g_nbytes_check
    $error("ula_seq only supports NBYTES = 4");
  end

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  localparam logic [2:0] OpEq  = 3'b100;
  localparam logic [2:0] OpAdd = 3'b101;
  localparam logic [2:0] OpBit = 3'b110;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [1:0]  len_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        cin_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic        eq_q;
  logic [31:0] result_q;
  logic        rsp_valid_q;
  logic        rsp_cout_q;

  logic [1:0]  a_sel;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic        last_byte;
  logic        eq_next;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] v);
    logic [31:0] r;
    r = w;
    r[{i, 3'b000} +: 8] = v;
    return r;
  endfunction

  // Bit-select picks its source byte from b[4:3] instead of the running index.
  always_comb begin
    a_sel     = (op_q == OpBit) ? b_q[4:3] : idx_q;
    a_byte    = get_byte(a_q, a_sel);
    b_byte    = get_byte(b_q, idx_q);
    last_byte = (op_q == OpBit) || (idx_q == len_q);
    eq_next   = eq_q & alu_s[0];
  end

  always_comb begin
    alu_op  = 3'b000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    if (state_q == StExec) begin
      alu_op  = op_q;
      alu_a   = a_byte;
      alu_b   = (op_q == OpBit) ? {5'b00000, b_q[2:0]} : b_byte;
      alu_cin = (op_q == OpAdd) ? carry_q : 1'b0;
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = rsp_valid_q;
    rsp_data  = result_q;
    rsp_cout  = rsp_cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 3'b000;
      len_q       <= 2'b00;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      cin_q       <= 1'b0;
      idx_q       <= 2'b00;
      carry_q     <= 1'b0;
      eq_q        <= 1'b1;
      result_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q       <= req_op;
            len_q      <= req_len;
            a_q        <= req_a;
            b_q        <= req_b;
            cin_q      <= req_cin;
            idx_q      <= 2'b00;
            carry_q    <= req_cin;
            eq_q       <= 1'b1;
            result_q   <= 32'h0;
            rsp_cout_q <= 1'b0;
            state_q    <= StExec;
          end
        end
        StExec: begin
          result_q <= put_byte(result_q, idx_q, alu_s);
          carry_q  <= alu_cout;
          eq_q     <= eq_next;
          if (last_byte) begin
            // Index parks at 0 rather than stepping past the last active byte.
            idx_q       <= 2'b00;
            rsp_valid_q <= 1'b1;
            rsp_cout_q  <= (op_q == OpAdd) & alu_cout;
            state_q     <= StDone;
            if (op_q == OpEq) begin
              result_q <= {31'h0, eq_next};
            end else if (op_q == OpBit) begin
              result_q <= {31'h0, alu_s[0]};
            end
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // cin_q is kept for observability of the latched request; carry_q does the work.
  logic unused_cin;
  assign unused_cin = cin_q;

  idx_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StExec) |-> (idx_q <= len_q));

  ready_only_idle_a: assert property (@(posedge clk) disable iff (!rst_n)
    req_ready |-> !busy);

  valid_only_done_a: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> (state_q == StDone));

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: behavioural 8-bit ALU, word-level reference
// model with a per-cycle compare process, directed cases and random traffic.
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_len;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_cin;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_s;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ula_seq #(.NBYTES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_len  (req_len),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_s    (alu_s),
    .alu_cout (alu_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_cout (rsp_cout),
    .busy     (busy)
  );

  // External 8-bit ALU; non-add carry-out is deliberately nonzero sometimes.
  always_comb begin
    alu_s    = 8'h00;
    alu_cout = alu_a[7];
    case (alu_op)
      3'd0: alu_s = alu_a & alu_b;
      3'd1: alu_s = alu_a | alu_b;
      3'd2: alu_s = alu_a ^ alu_b;
      3'd3: alu_s = ~alu_a;
      3'd4: alu_s = {7'd0, alu_a == alu_b};
      3'd5: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      3'd6: alu_s = {7'd0, alu_a[alu_b[2:0]]};
      default: alu_s = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  // Whole-word result {cout, data} from the operation definitions.
  function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [1:0] len,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic cin);
    logic [31:0] m;
    logic [32:0] s;
    int          nb;
    nb = int'(len) + 1;
    m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    s  = {1'b0, a & m} + {1'b0, b & m} + {32'd0, cin};
    case (op)
      3'd0: return {1'b0, a & b & m};
      3'd1: return {1'b0, (a | b) & m};
      3'd2: return {1'b0, (a ^ b) & m};
      3'd3: return {1'b0, ~a & m};
      3'd4: return {32'd0, (a & m) == (b & m)};
      3'd5: return {s[8*nb], s[31:0] & m};
      3'd6: return {32'd0, a[b[4:0]]};
      default: return 33'd0;
    endcase
  endfunction

  // Carry entering byte k of a+b+cin.
  function automatic logic carry_in(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input int k);
    logic [31:0] lm;
    logic [32:0] s;
    lm = (k == 0) ? 32'd0 : ((32'd1 << (8 * k)) - 32'd1);
    s  = {1'b0, a & lm} + {1'b0, b & lm} + {32'd0, cin};
    return s[8*k];
  endfunction

  // Model: 0 idle, 1 executing (m_k bytes done of m_n), 2 response pending.
  int          m_ph = 0;
  int          m_k  = 0;
  int          m_n  = 1;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a  = '0;
  logic [31:0] m_b  = '0;
  logic        m_cin = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0;
      m_k  <= 0;
    end else begin
      case (m_ph)
        0: if (req_valid) begin
          m_op              <= req_op;
          m_a               <= req_a;
          m_b               <= req_b;
          m_cin             <= req_cin;
          {m_cout, m_data}  <= ref_result(req_op, req_len, req_a, req_b, req_cin);
          m_n               <= (req_op == 3'd6) ? 1 : int'(req_len) + 1;
          m_k               <= 0;
          m_ph              <= 1;
        end
        1: begin
          m_k <= m_k + 1;
          if (m_k + 1 == m_n) m_ph <= 2;
        end
        default: if (rsp_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_ph == 0);
    chk("busy", busy, m_ph != 0);
    chk("rsp_valid", rsp_valid, m_ph == 2);
    if (!rst_n) begin
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
    end
    if (m_ph == 2) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_cout", rsp_cout, m_cout);
    end
    if (m_ph == 1) begin
      chk("alu_op", alu_op, m_op);
      if (m_op == 3'd6) begin
        chk("alu_a_bit", alu_a, byte_of(m_a, int'(m_b[4:3])));
        chk("alu_b_bit", alu_b, {5'd0, m_b[2:0]});
      end else begin
        chk("alu_a", alu_a, byte_of(m_a, m_k));
        chk("alu_b", alu_b, byte_of(m_b, m_k));
      end
      chk("alu_cin", alu_cin, (m_op == 3'd5) ? carry_in(m_a, m_b, m_cin, m_k) : 1'b0);
    end else begin
      chk("alu_idle", {alu_op, alu_a, alu_b, alu_cin}, 0);
    end
  end

  task automatic run_txn(input logic [2:0] op, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input int hold, input bit keep,
                         output int wait_cyc, output int lat, output logic [7:0] first_a,
                         output logic [7:0] first_b, output logic [31:0] d, output logic c);
    logic [32:0] exp;
    exp       = ref_result(op, len, a, b, cin);
    req_op    = op;
    req_len   = len;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_valid = 1'b1;
    wait_cyc  = 0;
    while (!req_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    first_a = alu_a;
    first_b = alu_b;
    if (!keep) req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp[31:0]);
      chk("hold_cout", rsp_cout, exp[32]);
      chk("hold_no_accept", req_ready, 0);
    end
    @(negedge clk);
    d = rsp_data;
    c = rsp_cout;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wc;
    int          lat;
    int          g;
    logic [7:0]  fa;
    logic [7:0]  fb;
    logic [31:0] d;
    logic        c;

    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_len   = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp", {rsp_data, rsp_cout}, 0);
    chk("reset_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);

    // Hand-computed results pinning the reference model.
    chk("ref_add32", ref_result(3'd5, 2'd3, 32'h00FF_FFFF, 32'h1, 1'b0), {1'b0, 32'h0100_0000});
    chk("ref_add16", ref_result(3'd5, 2'd1, 32'h0000_FFFF, 32'h1, 1'b0), {1'b1, 32'h0});
    chk("ref_not8", ref_result(3'd3, 2'd0, 32'h1234_5678, 32'h0, 1'b0), {1'b0, 32'h87});
    chk("ref_bit", ref_result(3'd6, 2'd3, 32'h8000_0000, 32'h1F, 1'b0), 33'd1);
    chk("ref_eq_ne", ref_result(3'd4, 2'd3, 32'h9234_5678, 32'h1234_5678, 1'b0), 33'd0);
    chk("ref_eq_low", ref_result(3'd4, 2'd2, 32'h9234_5678, 32'h1234_5678, 1'b0), 33'd1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn(3'd5, 2'd3, 32'h00FF_FFFF, 32'h1, 1'b0, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("first_accept_wait", wc, 0);
    chk("add32_data", d, 32'h0100_0000);
    chk("add32_cout", c, 0);
    chk("add32_latency", lat, 4);

    run_txn(3'd5, 2'd1, 32'h0000_FFFF, 32'h1, 1'b0, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("add16_data", d, 32'h0);
    chk("add16_cout", c, 1);
    chk("add16_latency", lat, 2);

    run_txn(3'd4, 2'd3, 32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("eq_same", d, 1);
    chk("eq_same_latency", lat, 4);
    run_txn(3'd4, 2'd3, 32'h9234_5678, 32'h1234_5678, 1'b0, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("eq_diff", d, 0);
    chk("eq_diff_latency", lat, 4);

    run_txn(3'd6, 2'd3, 32'h8000_0000, 32'h1F, 1'b0, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("bit_data", d, 1);
    chk("bit_latency", lat, 1);
    chk("bit_alu_a", fa, 8'h80);
    chk("bit_alu_b", fb, 8'h07);

    run_txn(3'd2, 2'd0, 32'hFFFF_FF0F, 32'hFFFF_FFF0, 1'b1, 0, 1'b0, wc, lat, fa, fb, d, c);
    chk("xor8_data", d, 32'hFF);
    chk("xor8_cout", c, 0);

    // Backpressure with req_valid held: no accept until after the handshake.
    run_txn(3'd5, 2'd1, 32'h0000_12FF, 32'h0000_0001, 1'b1, 5, 1'b1, wc, lat, fa, fb, d, c);
    chk("bp_data", d, 32'h1301);
    chk("bp_cout", c, 0);
    chk("bp_idle_after_handshake", req_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_second_accept", busy, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("bp_drain", busy, 0);
    rsp_ready = 1'b0;

    // Reset during the second EXEC cycle of a 4-byte add.
    req_op    = 3'd5;
    req_len   = 2'd3;
    req_a     = 32'h89AB_CDEF;
    req_b     = 32'h7654_3210;
    req_cin   = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_mid_started", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_rsp", {rsp_data, rsp_cout}, 0);
    chk("rst_mid_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Random traffic; fields change freely while busy and must be ignored.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = 3'($urandom);
      req_len   = 2'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      req_cin   = 1'($urandom);
      rsp_ready = ($urandom_range(0, 2) == 0);
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    g = 0;
    while (busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter: NBYTES, 4, maximum operand length in bytes; the only supported value is 4.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when high together with req_valid.
REQ-007 req_op  input  3  ALU opcode: 000 and, 001 or, 010 xor, 011 not, 100 eq, 101 add, 110 bit-select, 111 zero.
REQ-008 req_len  input  2  operand length minus one, in bytes (0 = 1 byte … 3 = 4 bytes).
REQ-009 req_a / req_b  input  32 each  operands.
REQ-010 req_cin  input  1  carry-in for add.
REQ-011 alu_op  output  3  opcode driven to the 8-bit ALU.
REQ-012 alu_a / alu_b  output  8 each  byte operands driven to the ALU.
REQ-013 alu_cin  output  1  carry driven to the ALU.
REQ-014 alu_s  input  8  ALU result, combinational from the alu_* outputs in the same cycle.
REQ-015 alu_cout  input  1  ALU carry-out.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-018 rsp_data  output  32  result.
REQ-019 rsp_cout  output  1  final carry; 0 for every operation except add.
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-022 req_ready SHALL be high only in IDLE, decoded combinationally from state.
REQ-023 In IDLE, on req_valid=1, the block SHALL:
- latch op, len, a, b and cin;
- clear the result register;
- set the byte index to 0, the carry to req_cin and the eq accumulator to 1;
- go to EXEC.
REQ-024 The EXEC length N SHALL be len+1 cycles for ops 000-101 and 111, and exactly 1 cycle for op 110 regardless of len.
REQ-025 Each EXEC cycle SHALL drive the following, and all alu_* outputs SHALL be 0 outside EXEC:
- alu_op = latched op;
- alu_a = a byte[idx], alu_b = b byte[idx];
- alu_cin = carry when op=101, else 0.
REQ-026 At the end of each EXEC cycle the block SHALL:
- store alu_s into result byte[idx];
- set carry to alu_cout;
- AND the eq accumulator with alu_s[0];
- increment idx.
REQ-027 Op 110 SHALL drive alu_a = a byte[b[4:3]] and alu_b = {5'b0, b[2:0]}, and SHALL set rsp_data = {31'b0, alu_s[0]}.
REQ-028 Op 100 SHALL set rsp_data = {31'b0, eq accumulator} after all N bytes.
REQ-029 Result bytes above len SHALL read 0 for ops 000-011, 101 and 111.
REQ-030 After the last EXEC cycle the state SHALL go to DONE, so rsp_valid rises N edges after the accept edge.
REQ-031 In DONE:
- rsp_valid=1;
- rsp_data and rsp_cout held stable until rsp_ready=1;
- on that edge, rsp_valid drops and the state returns to IDLE.
REQ-032 A new request SHALL NOT be accepted in the same cycle as a response handshake, so the minimum issue interval is N+2 cycles.
REQ-033 req_valid while busy=1 SHALL be ignored with no side effect.
REQ-034 rsp_cout SHALL equal the carry after the final byte when op=101, and 0 otherwise.
REQ-035 The byte index SHALL never exceed len; there is no wrap-around into unused bytes.

Reset
REQ-036 While rst_n=0 the block SHALL hold the following, and SHALL assert these values immediately on reset, independent of clk:
- state IDLE;
- rsp_valid=0, rsp_data=0, rsp_cout=0, busy=0;
- all alu_* outputs 0;
- idx=0, carry=0, eq accumulator=1;
- req_ready=1.
REQ-037 Reset asserted during EXEC or DONE SHALL abort the operation and produce no response after release.
REQ-038 The first request SHALL be accepted on the first rising edge after rst_n deasserts with req_valid=1.

Verification
REQ-039 32-bit add: a=0x00FFFFFF, b=0x00000001, cin=0, len=3 -> rsp_data=0x01000000, rsp_cout=0, rsp_valid 4 edges after accept.
REQ-040 16-bit add with carry-out: a=0x0000FFFF, b=0x00000001, len=1 -> rsp_data=0x00000000, rsp_cout=1; upper bytes 0.
REQ-041 eq: a=b=0x12345678, len=3 -> rsp_data=1; then a=0x92345678 -> rsp_data=0; 4 EXEC cycles each.
REQ-042 bit-select: op=110, a=0x80000000, b=0x1F, len=3 -> rsp_data=1 after one EXEC cycle; alu_a=0x80, alu_b=0x07 during EXEC.
REQ-043 Backpressure: rsp_ready held 0 for 5 cycles while req_valid=1 -> rsp_valid, rsp_data and rsp_cout stable, req_ready=0, no second accept; the second request is accepted only after the response handshake and return to IDLE.
REQ-044 Reset mid-EXEC: rst_n pulsed low at EXEC cycle 2 of a 4-byte add -> all outputs return to reset values asynchronously, with no rsp_valid afterwards.
